// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP control port: command codes,
// access FSM states, status bit positions and default I/O port decode.
package vdp_pkg;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } cmd_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_BUSY = 2'd2,
        ST_HOLD = 2'd3
    } acc_state_t;

    // Bit positions inside the status byte returned by a control read
    localparam int STAT_INT  = 7;
    localparam int STAT_OVF  = 6;
    localparam int STAT_COLL = 5;

    // Frame interrupt enable lives in register 1, bit 5
    localparam int IRQ_EN_REG = 1;
    localparam int IRQ_EN_BIT = 5;

    localparam logic [7:0] DEF_DATA_PORT = 8'hBE;
    localparam logic [7:0] DEF_CTRL_PORT = 8'hBF;
    localparam logic [7:0] DEF_PORT_MASK = 8'hFF;

endpackage

// File: rtl/vdp_bus_access_fsm.sv
// Z80 I/O cycle decoder. Detects a hit on the data or control port and walks
// IDLE/ACT/BUSY/HOLD so that exactly one action happens per Z80 cycle. The
// ACT state is the one-cycle action pulse; is_ctrl/is_write are captured on
// entry to ACT and stay valid for that cycle.
module vdp_bus_access_fsm
    import vdp_pkg::*;
#(
    parameter logic [7:0] DATA_PORT = DEF_DATA_PORT,
    parameter logic [7:0] CTRL_PORT = DEF_CTRL_PORT,
    parameter logic [7:0] PORT_MASK = DEF_PORT_MASK
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_addr,
    input  logic       i_iorq_l,
    input  logic       i_rd_l,
    input  logic       i_wr_l,
    input  logic       i_req_busy,
    input  logic       i_launch,
    input  logic       i_ack,
    output acc_state_t o_state,
    output logic       o_is_ctrl,
    output logic       o_is_write,
    output logic       o_wait_l
);

    logic       w_data_hit;
    logic       w_ctrl_hit;
    logic       w_hit;
    logic       w_wait_l;
    acc_state_t w_next;
    acc_state_t r_state;
    logic       r_is_ctrl;
    logic       r_is_write;

    // Port decode: masked address match, IORQ low, exactly one strobe low
    always_comb begin
        w_data_hit = ((i_addr & PORT_MASK) == (DATA_PORT & PORT_MASK));
        w_ctrl_hit = ((i_addr & PORT_MASK) == (CTRL_PORT & PORT_MASK));
        w_hit      = !i_iorq_l && (i_rd_l != i_wr_l) && (w_data_hit || w_ctrl_hit);
    end

    // Next state and WAIT_L; a hit while a VRAM request is still outstanding
    // parks in IDLE with WAIT_L low until the request has retired
    always_comb begin
        w_next   = r_state;
        w_wait_l = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    if (i_req_busy) w_wait_l = 1'b0;
                    else            w_next   = ST_ACT;
                end
            end
            ST_ACT:  w_next = i_launch ? ST_BUSY : ST_HOLD;
            ST_BUSY: begin
                w_wait_l = 1'b0;
                if (i_ack) w_next = ST_HOLD;
            end
            ST_HOLD: if (i_iorq_l) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register plus capture of the access type on entry to ACT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_is_ctrl  <= 1'b0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_next == ST_ACT) begin
                r_is_ctrl  <= w_ctrl_hit;
                r_is_write <= !i_wr_l;
            end
        end
    end

    assign o_state    = r_state;
    assign o_is_ctrl  = r_is_ctrl;
    assign o_is_write = r_is_write;
    assign o_wait_l   = w_wait_l;

endmodule

// File: rtl/vdp_ctrl_port.sv
// VDP control port: two-byte command assembly, auto-incrementing address,
// register file, status/interrupt, VRAM read-ahead buffer and CRAM writes.
// VRAM handshake: vram_req rises with vram_we/addr/wdata and all four hold
// steady until a one-cycle vram_ack; vram_req falls the cycle after ack and
// only one request is ever outstanding.
module vdp_ctrl_port
    import vdp_pkg::*;
#(
    parameter int         ADDR_W      = 14,
    parameter int         CRAM_ADDR_W = 5,
    parameter int         NUM_REGS    = 11,
    parameter logic [7:0] DATA_PORT   = DEF_DATA_PORT,
    parameter logic [7:0] CTRL_PORT   = DEF_CTRL_PORT,
    parameter logic [7:0] PORT_MASK   = DEF_PORT_MASK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             addr_in,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic                   IORQ_L,
    input  logic                   RD_L,
    input  logic                   WR_L,
    output logic                   WAIT_L,
    output logic                   INT_L,
    input  logic                   frame_irq,
    input  logic                   spr_ovf_set,
    input  logic                   spr_coll_set,
    output logic                   vram_req,
    output logic                   vram_we,
    output logic [ADDR_W-1:0]      vram_addr,
    output logic [7:0]             vram_wdata,
    input  logic [7:0]             vram_rdata,
    input  logic                   vram_ack,
    output logic                   cram_we,
    output logic [CRAM_ADDR_W-1:0] cram_addr,
    output logic [7:0]             cram_wdata,
    output logic [NUM_REGS*8-1:0]  reg_q
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    acc_state_t              w_state;
    logic                    w_is_ctrl, w_is_write, w_wait_l;
    logic                    w_act, w_ctrl_wr, w_ctrl_rd, w_data_wr, w_data_rd;
    logic                    w_launch, w_launch_we, w_reg_ok, w_cram_hit;
    logic [ADDR_W-1:0]       w_new_addr, w_launch_addr;
    logic [7:0]              w_status;

    logic [ADDR_W-1:0]       r_addr;
    cmd_code_t               r_code;
    logic                    r_flag;
    logic [7:0]              r_latch, r_rbuf, r_data_out;
    logic                    r_st_int, r_st_ovf, r_st_coll;
    logic [7:0]              r_regs [NUM_REGS];
    logic                    r_vram_req, r_vram_we;
    logic [ADDR_W-1:0]       r_vram_addr;
    logic [7:0]              r_vram_wdata;
    logic                    r_cram_we;
    logic [CRAM_ADDR_W-1:0]  r_cram_addr;
    logic [7:0]              r_cram_wdata;

    vdp_bus_access_fsm #(
        .DATA_PORT (DATA_PORT),
        .CTRL_PORT (CTRL_PORT),
        .PORT_MASK (PORT_MASK)
    ) u_fsm (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_addr     (addr_in),
        .i_iorq_l   (IORQ_L),
        .i_rd_l     (RD_L),
        .i_wr_l     (WR_L),
        .i_req_busy (r_vram_req),
        .i_launch   (w_launch),
        .i_ack      (vram_ack),
        .o_state    (w_state),
        .o_is_ctrl  (w_is_ctrl),
        .o_is_write (w_is_write),
        .o_wait_l   (w_wait_l)
    );

    // Action decode and selection of the VRAM request launched in ACT
    always_comb begin
        w_act      = (w_state == ST_ACT);
        w_ctrl_wr  = w_act &&  w_is_ctrl &&  w_is_write;
        w_ctrl_rd  = w_act &&  w_is_ctrl && !w_is_write;
        w_data_wr  = w_act && !w_is_ctrl &&  w_is_write;
        w_data_rd  = w_act && !w_is_ctrl && !w_is_write;
        w_new_addr = ADDR_W'({data_in, r_latch});
        w_reg_ok   = ({28'd0, data_in[3:0]} < NUM_REGS);
        w_cram_hit = w_data_wr && (r_code == CRAM_WR);
        w_status   = 8'h00;
        w_status[STAT_INT]  = r_st_int;
        w_status[STAT_OVF]  = r_st_ovf;
        w_status[STAT_COLL] = r_st_coll;
        w_launch      = 1'b0;
        w_launch_we   = 1'b0;
        w_launch_addr = r_addr;
        if (w_ctrl_wr && r_flag && (cmd_code_t'(data_in[7:6]) == VRAM_RD)) begin
            w_launch      = 1'b1;
            w_launch_addr = w_new_addr;
        end else if (w_data_wr && !w_cram_hit) begin
            w_launch    = 1'b1;
            w_launch_we = 1'b1;
        end else if (w_data_rd) begin
            w_launch = 1'b1;
        end
    end

    // Command assembly, address counter, read buffer, data_out and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_code     <= VRAM_RD;
            r_flag     <= 1'b0;
            r_latch    <= 8'h00;
            r_rbuf     <= 8'h00;
            r_data_out <= 8'h00;
            r_st_int   <= 1'b0;
            r_st_ovf   <= 1'b0;
            r_st_coll  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                if (!r_flag) begin
                    r_latch <= data_in;
                    r_flag  <= 1'b1;
                end else begin
                    r_flag <= 1'b0;
                    r_code <= cmd_code_t'(data_in[7:6]);
                    // A read command prefetches at the new address and steps past it
                    r_addr <= (cmd_code_t'(data_in[7:6]) == VRAM_RD) ? (w_new_addr + ADDR_ONE)
                                                                      : w_new_addr;
                end
            end
            if (w_data_wr) begin
                r_flag <= 1'b0;
                r_rbuf <= data_in;
                r_addr <= r_addr + ADDR_ONE;
            end
            if (w_data_rd) begin
                r_flag     <= 1'b0;
                r_data_out <= r_rbuf;
                r_addr     <= r_addr + ADDR_ONE;
            end
            if (w_ctrl_rd) begin
                r_flag     <= 1'b0;
                r_data_out <= w_status;
            end
            if (r_vram_req && vram_ack && !r_vram_we) r_rbuf <= vram_rdata;
            // Clear on status read, but a set pulse in the same cycle wins
            r_st_int  <= (r_st_int  && !w_ctrl_rd) || frame_irq;
            r_st_ovf  <= (r_st_ovf  && !w_ctrl_rd) || spr_ovf_set;
            r_st_coll <= (r_st_coll && !w_ctrl_rd) || spr_coll_set;
        end
    end

    // Register file; indices beyond NUM_REGS are silently dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
        end else if (w_ctrl_wr && r_flag && (cmd_code_t'(data_in[7:6]) == REG_WR) && w_reg_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (data_in[3:0] == i[3:0]) r_regs[i] <= r_latch;
            end
        end
    end

    // VRAM request holder: launch in ACT, retire on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vram_req   <= 1'b0;
            r_vram_we    <= 1'b0;
            r_vram_addr  <= '0;
            r_vram_wdata <= 8'h00;
        end else begin
            if (r_vram_req && vram_ack) r_vram_req <= 1'b0;
            if (w_launch) begin
                r_vram_req  <= 1'b1;
                r_vram_we   <= w_launch_we;
                r_vram_addr <= w_launch_addr;
                if (w_launch_we) r_vram_wdata <= data_in;
            end
        end
    end

    // CRAM write strobe is a single-cycle pulse; address/data hold afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cram_we    <= 1'b0;
            r_cram_addr  <= '0;
            r_cram_wdata <= 8'h00;
        end else begin
            r_cram_we <= w_cram_hit;
            if (w_cram_hit) begin
                r_cram_addr  <= r_addr[CRAM_ADDR_W-1:0];
                r_cram_wdata <= data_in;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[8*g +: 8] = r_regs[g];
    end

    assign data_out   = r_data_out;
    assign WAIT_L     = w_wait_l;
    assign INT_L      = !(r_st_int && r_regs[IRQ_EN_REG][IRQ_EN_BIT]);
    assign vram_req   = r_vram_req;
    assign vram_we    = r_vram_we;
    assign vram_addr  = r_vram_addr;
    assign vram_wdata = r_vram_wdata;
    assign cram_we    = r_cram_we;
    assign cram_addr  = r_cram_addr;
    assign cram_wdata = r_cram_wdata;

endmodule

// File: tb/tb_vdp_ctrl_port.sv
// Directed bench for vdp_ctrl_port: Z80 bus driver tasks, a VRAM arbiter
// responder that pops expected requests from a queue, and a CRAM monitor.
module tb_vdp_ctrl_port;

    localparam int ADDR_W      = 14;
    localparam int CRAM_ADDR_W = 5;
    localparam int NUM_REGS    = 11;
    localparam logic [7:0] DP = 8'hBE;
    localparam logic [7:0] CP = 8'hBF;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [7:0]             addr_in = 8'h00;
    logic [7:0]             data_in = 8'h00;
    logic [7:0]             data_out;
    logic                   IORQ_L = 1'b1;
    logic                   RD_L = 1'b1;
    logic                   WR_L = 1'b1;
    logic                   WAIT_L;
    logic                   INT_L;
    logic                   frame_irq = 1'b0;
    logic                   spr_ovf_set = 1'b0;
    logic                   spr_coll_set = 1'b0;
    logic                   vram_req;
    logic                   vram_we;
    logic [ADDR_W-1:0]      vram_addr;
    logic [7:0]             vram_wdata;
    logic [7:0]             vram_rdata = 8'h00;
    logic                   vram_ack = 1'b0;
    logic                   cram_we;
    logic [CRAM_ADDR_W-1:0] cram_addr;
    logic [7:0]             cram_wdata;
    logic [NUM_REGS*8-1:0]  reg_q;

    int checks   = 0;
    int failures = 0;

    logic [22:0] exp_q[$];           // {we, addr, wdata}
    logic [7:0]  tb_rdata = 8'h00;   // returned on the next read ack
    logic        ack_en = 1'b1;
    logic [22:0] rsp_cap, rsp_e;
    int          cram_cnt = 0;
    logic [12:0] last_cram = '0;
    logic [NUM_REGS*8-1:0] exp_regq = '0;
    logic [7:0]  rd;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    vdp_ctrl_port #(
        .ADDR_W      (ADDR_W),
        .CRAM_ADDR_W (CRAM_ADDR_W),
        .NUM_REGS    (NUM_REGS),
        .DATA_PORT   (DP),
        .CTRL_PORT   (CP),
        .PORT_MASK   (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_out     (data_out),
        .IORQ_L       (IORQ_L),
        .RD_L         (RD_L),
        .WR_L         (WR_L),
        .WAIT_L       (WAIT_L),
        .INT_L        (INT_L),
        .frame_irq    (frame_irq),
        .spr_ovf_set  (spr_ovf_set),
        .spr_coll_set (spr_coll_set),
        .vram_req     (vram_req),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .vram_rdata   (vram_rdata),
        .vram_ack     (vram_ack),
        .cram_we      (cram_we),
        .cram_addr    (cram_addr),
        .cram_wdata   (cram_wdata),
        .reg_q        (reg_q)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_cycle(input logic [7:0] port, input logic wr, input logic [7:0] wd,
                             input logic irq_at_act, output logic [7:0] rdv);
        int n;
        @(negedge clk);
        addr_in = port;
        data_in = wd;
        IORQ_L  = 1'b0;
        if (wr) WR_L = 1'b0;
        else    RD_L = 1'b0;
        @(negedge clk);
        if (irq_at_act) frame_irq = 1'b1;   // lands in the ACT cycle
        @(negedge clk);
        frame_irq = 1'b0;
        @(negedge clk);
        n = 0;
        while (WAIT_L !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_bound", WAIT_L, 1'b1);
        rdv = data_out;
        IORQ_L = 1'b1;
        WR_L   = 1'b1;
        RD_L   = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        logic [7:0] dummy;
        bus_cycle(CP, 1'b1, d, 1'b0, dummy);
    endtask

    task automatic data_wr(input logic [7:0] d);
        logic [7:0] dummy;
        bus_cycle(DP, 1'b1, d, 1'b0, dummy);
    endtask

    task automatic ctrl_rd(output logic [7:0] r);
        bus_cycle(CP, 1'b0, 8'h00, 1'b0, r);
    endtask

    task automatic data_rd(output logic [7:0] r);
        bus_cycle(DP, 1'b0, 8'h00, 1'b0, r);
    endtask

    task automatic pulse_status(input logic irq, input logic ovf, input logic coll);
        @(negedge clk);
        frame_irq    = irq;
        spr_ovf_set  = ovf;
        spr_coll_set = coll;
        @(negedge clk);
        frame_irq    = 1'b0;
        spr_ovf_set  = 1'b0;
        spr_coll_set = 1'b0;
    endtask

    // ---------------- VRAM arbiter responder / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (vram_req === 1'b1 && ack_en && !rst) begin
                rsp_cap = {vram_we, vram_addr, vram_wdata};
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("req_stable", {vram_req, vram_we, vram_addr, vram_wdata}, {1'b1, rsp_cap});
                check("req_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    rsp_e = exp_q.pop_front();
                    if (rsp_e[22]) check("vram_wr_req", {vram_we, vram_addr, vram_wdata}, rsp_e);
                    else           check("vram_rd_req", {vram_we, vram_addr}, rsp_e[22:8]);
                end
                vram_rdata = tb_rdata;
                vram_ack   = 1'b1;
                @(negedge clk);
                vram_ack   = 1'b0;
            end
        end
    end

    // CRAM strobe monitor
    initial begin
        forever begin
            @(negedge clk);
            if (cram_we === 1'b1) begin
                cram_cnt++;
                last_cram = {cram_addr, cram_wdata};
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {data_out, WAIT_L, INT_L, vram_req, vram_we, vram_addr, vram_wdata, cram_we, cram_addr, cram_wdata},
              {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 5'h00, 8'h00});
        check("reset_regs", reg_q, exp_regq);
        rst = 1'b0;
        @(negedge clk);

        // VRAM write at 0x1234, then auto-increment
        ctrl_wr(8'h34);
        ctrl_wr(8'h52);
        exp_q.push_back({1'b1, 14'h1234, 8'hAA});
        data_wr(8'hAA);
        exp_q.push_back({1'b1, 14'h1235, 8'hBB});
        data_wr(8'hBB);
        check("t1_drain", exp_q.size(), 0);

        // Register write uses the latched first byte; out-of-range index dropped
        ctrl_wr(8'h80);
        ctrl_wr(8'h81);
        exp_regq[15:8] = 8'h80;
        check("reg1_write", reg_q, exp_regq);
        check("reg_no_vram", vram_req, 1'b0);
        ctrl_wr(8'h55);
        ctrl_wr(8'h8F);
        check("reg_oob_drop", reg_q, exp_regq);

        // Address wrap from 0x3FFF to 0x0000
        ctrl_wr(8'hFF);
        ctrl_wr(8'h7F);
        exp_q.push_back({1'b1, 14'h3FFF, 8'h01});
        data_wr(8'h01);
        exp_q.push_back({1'b1, 14'h0000, 8'h02});
        data_wr(8'h02);
        check("wrap_drain", exp_q.size(), 0);

        // Read prefetch at 0x0100 and read-ahead buffer behaviour
        ctrl_wr(8'h00);
        tb_rdata = 8'h11;
        exp_q.push_back({1'b0, 14'h0100, 8'h00});
        ctrl_wr(8'h01);
        tb_rdata = 8'h22;
        exp_q.push_back({1'b0, 14'h0101, 8'h00});
        data_rd(rd);
        check("rd_buf_first", rd, 8'h11);
        tb_rdata = 8'h33;
        exp_q.push_back({1'b0, 14'h0102, 8'h00});
        data_rd(rd);
        check("rd_buf_second", rd, 8'h22);
        check("rd_drain", exp_q.size(), 0);

        // CRAM writes at address 3 then 4, no VRAM traffic
        ctrl_wr(8'h03);
        ctrl_wr(8'hC0);
        data_wr(8'h3C);
        check("cram_cnt1", cram_cnt, 1);
        check("cram_first", last_cram, {5'd3, 8'h3C});
        data_wr(8'h3D);
        check("cram_cnt2", cram_cnt, 2);
        check("cram_second", last_cram, {5'd4, 8'h3D});
        check("cram_no_vram", exp_q.size(), 0);

        // Frame interrupt, status read and set-wins-over-clear
        ctrl_wr(8'h20);
        ctrl_wr(8'h81);
        exp_regq[15:8] = 8'h20;
        check("reg1_irq_en", reg_q, exp_regq);
        check("int_idle", INT_L, 1'b1);
        pulse_status(1'b1, 1'b0, 1'b0);
        check("int_asserted", INT_L, 1'b0);
        ctrl_rd(rd);
        check("status_int", rd, 8'h80);
        check("int_cleared", INT_L, 1'b1);
        bus_cycle(CP, 1'b0, 8'h00, 1'b1, rd);
        check("status_coincident", rd, 8'h00);
        check("int_set_wins", INT_L, 1'b0);
        ctrl_rd(rd);
        check("status_after_coinc", rd, 8'h80);
        check("int_cleared2", INT_L, 1'b1);
        pulse_status(1'b1, 1'b1, 1'b1);
        ctrl_rd(rd);
        check("status_all", rd, 8'hE0);
        ctrl_rd(rd);
        check("status_empty", rd, 8'h00);

        // Control read clears the first-byte flag
        ctrl_wr(8'h12);
        ctrl_rd(rd);
        ctrl_wr(8'hC0);
        ctrl_wr(8'h82);
        exp_regq[23:16] = 8'hC0;
        check("flag_cleared_by_read", reg_q, exp_regq);

        // Reset while a VRAM write is waiting for its ack
        ctrl_wr(8'h00);
        ctrl_wr(8'h40);
        ack_en = 1'b0;
        @(negedge clk);
        addr_in = DP;
        data_in = 8'h77;
        IORQ_L  = 1'b0;
        WR_L    = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_req", {vram_req, WAIT_L}, {1'b1, 1'b0});
        #1 rst = 1'b1;
        #1 check("reset_abort", {vram_req, WAIT_L}, {1'b0, 1'b1});
        IORQ_L = 1'b1;
        WR_L   = 1'b1;
        repeat (2) @(negedge clk);
        exp_regq = '0;
        check("reset_regs2", reg_q, exp_regq);
        check("reset_out2", {data_out, INT_L}, {8'h00, 1'b1});
        rst    = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);

        // Fresh command after reset: flag starts clear
        ctrl_wr(8'h00);
        ctrl_wr(8'h40);
        exp_q.push_back({1'b1, 14'h0000, 8'h5A});
        data_wr(8'h5A);

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_ctrl_port.md
Name: vdp_ctrl_port

Overview:
Parametrised successor to the VDP port decoder and register file. It decodes Z80 I/O cycles to the data and control ports and assembles two-byte control commands (first-byte flag, code register, auto-incrementing VRAM address). It also owns the register file, the status/interrupt logic, a VRAM read-ahead buffer, and a req/ack handshake to the VRAM arbiter. It sits between the Z80 bus and the VRAM/CRAM/display blocks inside vdp_top.

Parameters:
ADDR_W, 14, VRAM address width; address wraps modulo 2^ADDR_W.
CRAM_ADDR_W, 5, CRAM address width; CRAM address is the low CRAM_ADDR_W bits of the address register.
NUM_REGS, 11, number of 8-bit VDP registers (max 16).
DATA_PORT, 8'hBE, data port I/O address.
CTRL_PORT, 8'hBF, control port I/O address.
PORT_MASK, 8'hFF, decode mask; supports mirrored ports (e.g. 8'hC1).

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-high reset
addr_in  in  8  Z80 address low byte
data_in  in  8  Z80 write data
data_out  out  8  read data (status or read buffer)
IORQ_L  in  1  Z80 I/O request, active low
RD_L  in  1  Z80 read strobe, active low
WR_L  in  1  Z80 write strobe, active low
WAIT_L  out  1  Z80 wait, active low
INT_L  out  1  frame interrupt to Z80, active low
frame_irq  in  1  one-cycle vblank pulse from display
spr_ovf_set  in  1  sprite overflow pulse
spr_coll_set  in  1  sprite collision pulse
vram_req  out  1  VRAM access request
vram_we  out  1  1 = write, 0 = read
vram_addr  out  ADDR_W  VRAM address
vram_wdata  out  8  VRAM write data
vram_rdata  in  8  VRAM read data, valid with vram_ack
vram_ack  in  1  one-cycle grant/complete
cram_we  out  1  CRAM write strobe (one cycle)
cram_addr  out  CRAM_ADDR_W  CRAM address
cram_wdata  out  8  CRAM write data
reg_q  out  NUM_REGS*8  flattened register contents; reg i occupies bits [8i+7:8i]

Behaviour:
- Reset: all outputs are 0, except WAIT_L=1 and INT_L=1. Address, code, flag, latch, read buffer, status and all registers clear to 0. Reset asserted mid-operation aborts any pending request immediately.
- Port hit: (addr_in & PORT_MASK) == (DATA_PORT or CTRL_PORT & PORT_MASK), with IORQ_L=0 and exactly one of RD_L/WR_L low.
- Access FSM:
  - IDLE --hit--> ACT: one cycle; performs the action below.
  - ACT --> BUSY if a VRAM request is outstanding, else HOLD.
  - BUSY: WAIT_L=0 until vram_ack, then HOLD.
  - HOLD --IORQ_L=1--> IDLE.
  - Exactly one action is performed per Z80 cycle, regardless of cycle length.
- Control write, flag=0: latch = data_in; flag = 1.
- Control write, flag=1: addr[ADDR_W-1:8] = data_in low bits; addr[7:0] = latch; code = data_in[7:6]; flag = 0. Then by code:
  - 0: VRAM read prefetch at the new address; address increments.
  - 1: VRAM write mode.
  - 2: reg[data_in[3:0]] = latch; the write is dropped if the index >= NUM_REGS.
  - 3: CRAM write mode.
- Data write: flag = 0; read buffer = data_in.
  - Code 3: cram_we pulses for one cycle with cram_addr = addr low bits.
  - Otherwise: VRAM write request to addr.
  - Address then increments, wrapping from 2^ADDR_W-1 to 0.
- Data read: data_out = read buffer (value before prefetch); flag = 0. Then a VRAM read prefetch at addr; address increments. vram_rdata loads the read buffer on ack.
- Control read: data_out = {int_pending, spr_ovf, spr_coll, 5'b0}. The three status bits clear after the read; flag = 0.
- Status set pulses arriving in the same cycle as a clearing control read: set wins.
- INT_L = ~(int_pending & reg_q[1*8+5]). Combinational from registers.
- VRAM handshake:
  - vram_req, vram_we, vram_addr and vram_wdata stay stable until vram_ack.
  - At most one request is outstanding; vram_req drops the cycle after ack.
  - A new port hit while a request is outstanding waits in IDLE with WAIT_L=0 until ack.
- data_out holds its last value outside read cycles.

Decomposition:
- vdp_pkg:
  - cmd_code_t enum {VRAM_RD=0, VRAM_WR=1, REG_WR=2, CRAM_WR=3}
  - status bit indices (INT=7, OVF=6, COLL=5)
  - IRQ enable index (reg 1, bit 5)
  - default port constants
- Sub-module vdp_bus_access_fsm: port-hit decode plus IDLE/ACT/BUSY/HOLD; emits a one-cycle act pulse with is_ctrl/is_write.

Test Plan:
- Control write 0x34 then 0x52, then data write 0xAA → vram_req, we=1, addr=0x1234, wdata=0xAA; after ack, addr=0x1235.
- Control write 0x80 then 0x81 → reg_q[1]=0x80 (not 0x81), with no VRAM request. With NUM_REGS=11, writing 0x55 then 0x8F leaves all registers unchanged.
- Set address 0x3FFF with code 1, then two data writes → VRAM writes to 0x3FFF then 0x0000.
- Code 0 at 0x0100 with vram_rdata=0x11 on ack, then data read → data_out=0x11 and a new read request at 0x0101.
- reg1=0x20, frame_irq pulse → INT_L=0. A control read returns 0x80 and INT_L returns to 1. A frame_irq coincident with the read leaves INT_L=0.
- First control byte, then a control read, then 0xC0 → 0xC0 is treated as a first byte (flag cleared by the read). Asserting rst mid-BUSY → vram_req=0 and WAIT_L=1 immediately.
